// File: rtl/hazard_scoreboard_if.sv
// Bundle between the decode-stage latches and the hazard scoreboard.
// Handshake: fd_valid/dx_valid qualify fd_ir/dx_ir; stall=1 means F/D is not accepted this cycle and D/X receives a bubble.
interface hazard_scoreboard_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      fd_ir;
  logic             fd_valid;
  logic [31:0]      dx_ir;
  logic             dx_valid;
  logic             md_done;
  logic             stall;
  logic [1:0]       stall_cause;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output fd_ir, fd_valid, dx_ir, dx_valid, md_done,
    input  stall, stall_cause, stall_cycles
  );

  modport slave (
    input  fd_ir, fd_valid, dx_ir, dx_valid, md_done,
    output stall, stall_cause, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Pipeline interlock: load-use countdown per register, mult/div busy tracking
// and a saturating stall-cycle counter.
module hazard_scoreboard #(
  parameter int LOAD_LAT         = 1,
  parameter int NUM_REGS         = 32,
  parameter int CNT_W            = 16,
  parameter int STORE_DATA_CHECK = 0
) (
  input logic                clock,
  input logic                reset,
  hazard_scoreboard_if.slave bus
);
  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;
  localparam logic [2:0] LD_INIT = 3'(LOAD_LAT - 1);

  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt, fd_alu;
  logic [4:0] dx_op, dx_rd, dx_alu;
  logic [4:0] src_a, src_b, fd_dst;
  logic       fd_md, dx_md, dx_lw;
  logic       ld_pend, ld_hit, md_hit, stall_int;
  logic [1:0] cause_int;
  logic       unused_bits;

  logic [2:0]       ld_cnt [NUM_REGS];
  logic             md_busy;
  logic [4:0]       md_dst;
  logic [CNT_W-1:0] cycles_q;

  assign fd_op  = bus.fd_ir[31:27];
  assign fd_rd  = bus.fd_ir[26:22];
  assign fd_rs  = bus.fd_ir[21:17];
  assign fd_rt  = bus.fd_ir[16:12];
  assign fd_alu = bus.fd_ir[6:2];
  assign dx_op  = bus.dx_ir[31:27];
  assign dx_rd  = bus.dx_ir[26:22];
  assign dx_alu = bus.dx_ir[6:2];
  assign unused_bits = ^{bus.fd_ir[11:7], bus.fd_ir[1:0], bus.dx_ir[21:7], bus.dx_ir[1:0]};

  // Register 0 never participates in a hazard, on either side of the compare.
  function automatic logic reg_match(input logic [4:0] r, input logic [4:0] a, input logic [4:0] b);
    return (r != 5'd0) && ((r == a) || (r == b));
  endfunction

  always_comb begin
    src_a = 5'd0;
    src_b = 5'd0;
    case (fd_op)
      OP_R:          begin src_a = fd_rs; src_b = fd_rt; end
      OP_ADDI, OP_LW: src_a = fd_rs;
      OP_SW:         begin src_a = fd_rs; src_b = (STORE_DATA_CHECK != 0) ? fd_rd : 5'd0; end
      OP_BNE, OP_BLT: begin src_a = fd_rd; src_b = fd_rs; end
      OP_JR:         src_a = fd_rd;
      default:       ;
    endcase
  end

  assign fd_dst = (fd_op == OP_R || fd_op == OP_ADDI || fd_op == OP_LW) ? fd_rd : 5'd0;
  assign fd_md  = (fd_op == OP_R) && (fd_alu == ALU_MUL || fd_alu == ALU_DIV);
  assign dx_md  = bus.dx_valid && (dx_op == OP_R) && (dx_alu == ALU_MUL || dx_alu == ALU_DIV);
  assign dx_lw  = bus.dx_valid && (dx_op == OP_LW);

  // ld_cnt[0] is never loaded, so scanning it is harmless.
  always_comb begin
    ld_pend = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ld_cnt[i] != 3'd0 && (src_a == 5'(i) || src_b == 5'(i))) ld_pend = 1'b1;
    end
  end

  assign ld_hit = (dx_lw && reg_match(dx_rd, src_a, src_b)) || ld_pend;
  assign md_hit = (md_busy && (reg_match(md_dst, src_a, src_b) || reg_match(md_dst, fd_dst, fd_dst) || fd_md))
               || (dx_md && (reg_match(dx_rd, src_a, src_b) || reg_match(dx_rd, fd_dst, fd_dst) || fd_md));
  assign stall_int = bus.fd_valid && (ld_hit || md_hit);

  always_comb begin
    cause_int = 2'b00;
    if (stall_int) cause_int = ld_hit ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) ld_cnt[i] <= 3'd0;
      md_busy  <= 1'b0;
      md_dst   <= 5'd0;
      cycles_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (dx_lw && dx_rd != 5'd0 && dx_rd == 5'(i)) ld_cnt[i] <= LD_INIT;
        else if (ld_cnt[i] != 3'd0)                  ld_cnt[i] <= ld_cnt[i] - 3'd1;
      end
      // A new mult/div start takes precedence over a completion in the same cycle.
      if (dx_md) begin
        md_busy <= 1'b1;
        md_dst  <= dx_rd;
      end else if (bus.md_done) begin
        md_busy <= 1'b0;
      end
      if (stall_int && cycles_q != '1) cycles_q <= cycles_q + CNT_W'(1);
    end
  end

  assign bus.stall        = stall_int;
  assign bus.stall_cause  = cause_int;
  assign bus.stall_cycles = cycles_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: two scoreboards (LOAD_LAT=1/SDC=0/CNT_W=16 and
// LOAD_LAT=3/SDC=1/CNT_W=4) share every stimulus vector.
module tb_hazard_scoreboard;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  hazard_scoreboard_if #(.CNT_W(16)) if_a ();
  hazard_scoreboard_if #(.CNT_W(4))  if_b ();

  hazard_scoreboard #(.LOAD_LAT(1), .NUM_REGS(32), .CNT_W(16), .STORE_DATA_CHECK(0)) dut_a (
    .clock(clock), .reset(reset), .bus(if_a)
  );
  hazard_scoreboard #(.LOAD_LAT(3), .NUM_REGS(32), .CNT_W(4), .STORE_DATA_CHECK(1)) dut_b (
    .clock(clock), .reset(reset), .bus(if_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] alu);
    return {op, rd, rs, rt, 5'b00000, alu, 2'b00};
  endfunction

  // Inputs change on the falling edge; outputs are sampled 2 time units later.
  task automatic step(input logic rst_n, input logic [31:0] fd, input logic fdv,
                      input logic [31:0] dx, input logic dxv, input logic done);
    @(negedge clock);
    reset         = rst_n;
    if_a.fd_ir    = fd;  if_b.fd_ir    = fd;
    if_a.fd_valid = fdv; if_b.fd_valid = fdv;
    if_a.dx_ir    = dx;  if_b.dx_ir    = dx;
    if_a.dx_valid = dxv; if_b.dx_valid = dxv;
    if_a.md_done  = done; if_b.md_done = done;
    #2;
  endtask

  task automatic exp_stall(input string tag, input logic sa, input logic [1:0] ca,
                           input logic sb, input logic [1:0] cb);
    check({tag, "/a_stall"}, 32'(if_a.stall), 32'(sa));
    check({tag, "/a_cause"}, 32'(if_a.stall_cause), 32'(ca));
    check({tag, "/b_stall"}, 32'(if_b.stall), 32'(sb));
    check({tag, "/b_cause"}, 32'(if_b.stall_cause), 32'(cb));
  endtask

  task automatic exp_cycles(input string tag, input int a, input int b);
    check({tag, "/a_cycles"}, 32'(if_a.stall_cycles), 32'(a));
    check({tag, "/b_cycles"}, 32'(if_b.stall_cycles), 32'(b));
  endtask

  initial begin
    logic [31:0] nop, lw5, lw0, lw7, add_6_5_7, addi_8_9, addi_10_11, add_1_5_0, add_1_0_2;
    logic [31:0] sw_5_2, sw_3_5, mul4, div9, add_1_4_2, add_1_9_2, addi_9_3, mul_1_2_3, add_1_7_9;
    nop        = enc(5'b11111, 5'd0, 5'd0, 5'd0, 5'd0);
    lw5        = enc(5'b01000, 5'd5, 5'd0, 5'd0, 5'd0);
    lw0        = enc(5'b01000, 5'd0, 5'd3, 5'd0, 5'd0);
    lw7        = enc(5'b01000, 5'd7, 5'd0, 5'd0, 5'd0);
    add_6_5_7  = enc(5'b00000, 5'd6, 5'd5, 5'd7, 5'd0);
    addi_8_9   = enc(5'b00101, 5'd8, 5'd9, 5'd0, 5'd0);
    addi_10_11 = enc(5'b00101, 5'd10, 5'd11, 5'd0, 5'd0);
    add_1_5_0  = enc(5'b00000, 5'd1, 5'd5, 5'd0, 5'd0);
    add_1_0_2  = enc(5'b00000, 5'd1, 5'd0, 5'd2, 5'd0);
    sw_5_2     = enc(5'b00111, 5'd5, 5'd2, 5'd0, 5'd0);
    sw_3_5     = enc(5'b00111, 5'd3, 5'd5, 5'd0, 5'd0);
    mul4       = enc(5'b00000, 5'd4, 5'd1, 5'd2, 5'b00110);
    div9       = enc(5'b00000, 5'd9, 5'd1, 5'd2, 5'b00111);
    add_1_4_2  = enc(5'b00000, 5'd1, 5'd4, 5'd2, 5'd0);
    add_1_9_2  = enc(5'b00000, 5'd1, 5'd9, 5'd2, 5'd0);
    addi_9_3   = enc(5'b00101, 5'd9, 5'd3, 5'd0, 5'd0);
    mul_1_2_3  = enc(5'b00000, 5'd1, 5'd2, 5'd3, 5'b00110);
    add_1_7_9  = enc(5'b00000, 5'd1, 5'd7, 5'd9, 5'd0);

    // Reset
    step(1'b0, nop, 1'b0, nop, 1'b0, 1'b0);
    step(1'b0, nop, 1'b0, nop, 1'b0, 1'b0);
    exp_stall("rst", 1'b0, 2'b00, 1'b0, 2'b00);
    step(1'b1, nop, 1'b0, nop, 1'b0, 1'b0);
    exp_cycles("rst", 0, 0);

    // Classic load-use; B keeps stalling on its countdown
    step(1'b1, add_6_5_7, 1'b1, lw5, 1'b1, 1'b0);
    exp_stall("lu1", 1'b1, 2'b01, 1'b1, 2'b01);
    step(1'b1, add_6_5_7, 1'b1, nop, 1'b0, 1'b0);
    exp_stall("lu2", 1'b0, 2'b00, 1'b1, 2'b01);
    step(1'b1, nop, 1'b1, add_6_5_7, 1'b1, 1'b0);
    exp_stall("lu3", 1'b0, 2'b00, 1'b0, 2'b00);

    // Consumer two cycles after the load left D/X
    step(1'b1, addi_8_9, 1'b1, lw5, 1'b1, 1'b0);
    exp_stall("lat1", 1'b0, 2'b00, 1'b0, 2'b00);
    step(1'b1, addi_10_11, 1'b1, addi_8_9, 1'b1, 1'b0);
    exp_stall("lat2", 1'b0, 2'b00, 1'b0, 2'b00);
    step(1'b1, add_1_5_0, 1'b1, addi_10_11, 1'b1, 1'b0);
    exp_stall("lat3", 1'b0, 2'b00, 1'b1, 2'b01);
    step(1'b1, add_1_5_0, 1'b1, nop, 1'b0, 1'b0);
    exp_stall("lat4", 1'b0, 2'b00, 1'b0, 2'b00);
    step(1'b1, add_1_0_2, 1'b1, lw0, 1'b1, 1'b0);
    exp_stall("r0a", 1'b0, 2'b00, 1'b0, 2'b00);
    step(1'b1, add_1_0_2, 1'b1, nop, 1'b0, 1'b0);
    exp_stall("r0b", 1'b0, 2'b00, 1'b0, 2'b00);

    // Store data register vs. base register
    step(1'b1, sw_5_2, 1'b1, lw5, 1'b1, 1'b0);
    exp_stall("swd", 1'b0, 2'b00, 1'b1, 2'b01);
    step(1'b1, nop, 1'b1, nop, 1'b0, 1'b0);
    exp_stall("swd_n1", 1'b0, 2'b00, 1'b0, 2'b00);
    step(1'b1, nop, 1'b1, nop, 1'b0, 1'b0);
    exp_stall("swd_n2", 1'b0, 2'b00, 1'b0, 2'b00);
    step(1'b1, sw_3_5, 1'b1, lw5, 1'b1, 1'b0);
    exp_stall("swb1", 1'b1, 2'b01, 1'b1, 2'b01);
    step(1'b1, sw_3_5, 1'b1, nop, 1'b0, 1'b0);
    exp_stall("swb2", 1'b0, 2'b00, 1'b1, 2'b01);
    step(1'b1, sw_3_5, 1'b1, nop, 1'b0, 1'b0);
    exp_stall("swb3", 1'b0, 2'b00, 1'b1, 2'b01);
    step(1'b1, sw_3_5, 1'b1, nop, 1'b0, 1'b0);
    exp_cycles("sw", 2, 7);
    exp_stall("swb4", 1'b0, 2'b00, 1'b0, 2'b00);

    // Mult/div busy interlock for 17 cycles; B's 4-bit counter saturates
    step(1'b0, nop, 1'b0, nop, 1'b0, 1'b0);
    step(1'b1, add_1_4_2, 1'b1, mul4, 1'b1, 1'b0);
    exp_cycles("md0", 0, 0);
    exp_stall("md1", 1'b1, 2'b10, 1'b1, 2'b10);
    for (int c = 2; c <= 16; c++) begin
      step(1'b1, add_1_4_2, 1'b1, nop, 1'b0, 1'b0);
      exp_stall($sformatf("md%0d", c), 1'b1, 2'b10, 1'b1, 2'b10);
    end
    step(1'b1, add_1_4_2, 1'b1, nop, 1'b0, 1'b1);
    exp_cycles("md17", 16, 15);
    exp_stall("md17", 1'b1, 2'b10, 1'b1, 2'b10);
    step(1'b1, add_1_4_2, 1'b1, nop, 1'b0, 1'b0);
    exp_cycles("md18", 17, 15);
    exp_stall("md18", 1'b0, 2'b00, 1'b0, 2'b00);

    // md_done together with a new div: the div wins
    step(1'b1, nop, 1'b1, mul4, 1'b1, 1'b0);
    exp_stall("sim1", 1'b0, 2'b00, 1'b0, 2'b00);
    step(1'b1, nop, 1'b1, div9, 1'b1, 1'b1);
    exp_stall("sim2", 1'b0, 2'b00, 1'b0, 2'b00);
    step(1'b1, add_1_4_2, 1'b1, nop, 1'b0, 1'b0);
    exp_stall("sim_r4", 1'b0, 2'b00, 1'b0, 2'b00);
    step(1'b1, add_1_9_2, 1'b1, nop, 1'b0, 1'b0);
    exp_stall("sim_r9", 1'b1, 2'b10, 1'b1, 2'b10);
    step(1'b1, addi_9_3, 1'b1, nop, 1'b0, 1'b0);
    exp_stall("sim_waw", 1'b1, 2'b10, 1'b1, 2'b10);
    step(1'b1, mul_1_2_3, 1'b1, nop, 1'b0, 1'b0);
    exp_stall("sim_md", 1'b1, 2'b10, 1'b1, 2'b10);
    step(1'b1, add_1_4_2, 1'b1, nop, 1'b1 & 1'b0, 1'b0);
    exp_stall("sim_ind", 1'b0, 2'b00, 1'b0, 2'b00);

    // Reset in the middle of a stall with a load counter and busy loaded
    step(1'b1, nop, 1'b1, lw7, 1'b1, 1'b0);
    exp_stall("mr1", 1'b0, 2'b00, 1'b0, 2'b00);
    step(1'b1, add_1_7_9, 1'b1, nop, 1'b0, 1'b0);
    exp_stall("mr2", 1'b1, 2'b10, 1'b1, 2'b01);
    step(1'b0, add_1_7_9, 1'b1, nop, 1'b0, 1'b0);
    exp_stall("mr3", 1'b1, 2'b10, 1'b1, 2'b01);
    step(1'b1, add_1_7_9, 1'b1, nop, 1'b0, 1'b1);
    exp_cycles("mr4", 0, 0);
    exp_stall("mr4", 1'b0, 2'b00, 1'b0, 2'b00);
    step(1'b1, add_1_7_9, 1'b1, nop, 1'b0, 1'b0);
    exp_cycles("mr5", 0, 0);
    exp_stall("mr5", 1'b0, 2'b00, 1'b0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
